fb_scan_ctrl: RTL and testbench
===============================

# fb_scan_ctrl

Read-side sequencer for the dual-port frame buffer. On a start pulse it walks the buffer's read port linearly over one H_RES×V_RES frame starting at BASE. It absorbs the RAM's one-cycle read latency and presents pixels on a valid/ready stream with end-of-line and end-of-frame markers. It sits between the frame buffer's read port (addr_out / regread / data_out) and the display or transmit pipeline.

## Interface
- AW, 17, frame-buffer address width
- DW, 16, pixel width
- H_RES, 160, pixels per line
- V_RES, 120, lines per frame
- BASE, 0, first frame address; BASE + H_RES*V_RES - 1 must be ≤ 2^AW - 1 (elaboration-time check)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame scan; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel handshake
- mem_addr  out  AW  to frame buffer addr_out
- mem_rd  out  1  to frame buffer regread
- mem_data  in  DW  from frame buffer data_out, valid one cycle after mem_rd
- px_data  out  DW  pixel
- px_valid  out  1  pixel available
- px_ready  in  1  downstream accepts; handshake = px_valid & px_ready
- px_eol  out  1  qualifies px_data as last pixel of a line
- px_eof  out  1  qualifies px_data as last pixel of the frame (eol also set)

## Operation
- States: IDLE → RUN on start. RUN → DRAIN when the read of address BASE+H_RES*V_RES-1 issues. DRAIN → IDLE when the FIFO is empty and no read is in flight after the eof handshake; done pulses on that transition.
- Read counter: AW bits, loaded with BASE on start, +1 per issued read. It never wraps within a frame.
- Line counter x: $clog2(H_RES) bits, 0..H_RES-1; line counter y: 0..V_RES-1. Both advance per issued read. eol = (x==H_RES-1); eof = eol & (y==V_RES-1). The flags are delayed alongside the read and stored with the data.
- Output buffer: 2-entry FIFO of {data, eol, eof}, count C ∈ {0,1,2}. F = 1 when a read issued last cycle (its data lands in the FIFO at the end of this cycle).
- Issue rule (combinational): mem_rd = (state==RUN) & (C + F - pop < 2), where pop = px_valid & px_ready. This gives a sustained 1 pixel/cycle with px_ready high, and the FIFO never overflows.
- mem_addr holds the current read counter. mem_rd is 0 outside RUN.
- start in RUN, DRAIN, or in the done cycle: ignored.
- px_data/px_eol/px_eof are stable while px_valid & !px_ready.
- Reset (any state): next cycle state=IDLE; busy=0, done=0, mem_rd=0, px_valid=0, px_eol=0, px_eof=0, px_data=0, mem_addr=BASE; FIFO and in-flight flag cleared. Data returning from a pre-reset read is discarded.

## Timing
- start sampled at the edge closing cycle n. Cycle n+1: busy=1, mem_rd=1, mem_addr=BASE. Cycle n+2: mem_data valid. Cycle n+3: px_valid=1 with the BASE pixel.
- Start-to-first-pixel latency: 3 cycles. With px_ready held high, pixels are back-to-back; the last pixel appears at n+2+H_RES*V_RES.
- done is high in the cycle after the eof handshake; busy falls in the same cycle.
- Combinational path px_ready → mem_rd is permitted. There is no combinational path to px_valid.

## Structure
- Package fb_pkg: AW, DW, H_RES, V_RES defaults; typedef px_entry_t {data, eol, eof}; state enum {IDLE, RUN, DRAIN}.
- Sub-module fb_skid_fifo: 2-entry FIFO of px_entry_t with count output and synchronous reset.
- Top-level fb_scan_ctrl: FSM, read/x/y counters, in-flight flag, issue logic.

## Test plan
Bench setup: H_RES=4, V_RES=3, BASE=0x10; behavioural RAM model with mem[a]=a.
1. px_ready=1, start at cycle n → px_valid from n+3, data 0x10..0x1B on 12 consecutive cycles; eol on 0x13/0x17/0x1B; eof only on 0x1B; done at n+15.
2. px_ready pattern 1,0,1,0… → all 12 values delivered once, in order; px_data stable while stalled; C never exceeds 2.
3. px_ready=0 for 20 cycles after the first px_valid → exactly 2 reads issued then mem_rd=0; on release the remaining 10 pixels stream without loss.
4. start pulsed at n+5 during RUN → no effect; a single frame and a single done.
5. rst at the 6th handshake → next cycle all outputs at reset values; a new start yields 0x10 first and a complete 12-pixel frame.
6. BASE=2^AW-12 → last mem_addr=2^AW-1, no wrap, eof on that pixel, done pulses.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and default sizing for the frame-buffer read-side sequencer.
package fb_pkg;

  localparam int DEF_AW    = 17;
  localparam int DEF_DW    = 16;
  localparam int DEF_H_RES = 160;
  localparam int DEF_V_RES = 120;

  typedef struct packed {
    logic [DEF_DW-1:0] data;
    logic              eol;
    logic              eof;
  } px_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry pixel FIFO that absorbs the RAM read latency and downstream back-pressure.
module fb_skid_fifo
  import fb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  px_entry_t wdata_i,
  output px_entry_t rdata_o,
  output logic [1:0] count_o
);

  px_entry_t  mem_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] count_q;

  // The issue logic upstream guarantees push never hits a full FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= wdata_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop_i) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fb_scan_ctrl.sv
// Walks the frame-buffer read port over one frame and streams pixels with eol/eof markers.
module fb_scan_ctrl
  import fb_pkg::*;
#(
  parameter int     AW    = DEF_AW,
  parameter int     DW    = DEF_DW,
  parameter int     H_RES = DEF_H_RES,
  parameter int     V_RES = DEF_V_RES,
  parameter longint BASE  = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_rd_o,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] px_data_o,
  output logic          px_valid_o,
  input  logic          px_ready_i,
  output logic          px_eol_o,
  output logic          px_eof_o
);

  localparam int            XW        = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int            YW        = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam longint        LAST_ADDR = BASE + longint'(H_RES) * longint'(V_RES) - 1;
  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);

  if (LAST_ADDR > ((longint'(1) << AW) - 1)) begin : gBadBase
    $error("fb_scan_ctrl: frame does not fit in the address space");
  end
  if (DW != DEF_DW) begin : gBadWidth
    $error("fb_scan_ctrl: DW must match fb_pkg pixel width");
  end

  state_e         state_q, state_d;
  logic [AW-1:0]  rdAddr_q, rdAddr_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           inFlight_q;
  logic           eolDly_q, eofDly_q;

  logic [1:0]     fifoCount;
  px_entry_t      fifoIn, fifoHead;
  logic [2:0]     occupancy;
  logic           pop, issue, curEol, curEof;

  assign curEol    = (x_q == XW'(H_RES - 1));
  assign curEof    = curEol && (y_q == YW'(V_RES - 1));
  assign pop       = px_valid_o && px_ready_i;
  // Slots that will be taken next cycle: stored + landing - leaving.
  assign occupancy = {1'b0, fifoCount} + {2'b00, inFlight_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (occupancy < 3'd2);

  always_comb begin
    state_d  = state_q;
    rdAddr_d = rdAddr_q;
    x_d      = x_q;
    y_d      = y_q;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          rdAddr_d = BASE_ADDR;
          x_d      = '0;
          y_d      = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (curEof) begin
            state_d = DRAIN;
          end else begin
            rdAddr_d = rdAddr_q + AW'(1);
            if (curEol) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (fifoCount == 2'd0 && !inFlight_q) begin
          done_o   = 1'b1;
          state_d  = IDLE;
          rdAddr_d = BASE_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags travel with the read so they land in the FIFO beside their data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rdAddr_q   <= BASE_ADDR;
      x_q        <= '0;
      y_q        <= '0;
      inFlight_q <= 1'b0;
      eolDly_q   <= 1'b0;
      eofDly_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdAddr_q   <= rdAddr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inFlight_q <= issue;
      if (issue) begin
        eolDly_q <= curEol;
        eofDly_q <= curEof;
      end
    end
  end

  assign fifoIn = '{data: mem_data_i, eol: eolDly_q, eof: eofDly_q};

  fb_skid_fifo uFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inFlight_q),
    .pop_i   (pop),
    .wdata_i (fifoIn),
    .rdata_o (fifoHead),
    .count_o (fifoCount)
  );

  assign px_valid_o = (fifoCount != 2'd0);
  assign px_data_o  = fifoHead.data;
  assign px_eol_o   = px_valid_o && fifoHead.eol;
  assign px_eof_o   = px_valid_o && fifoHead.eof;
  assign busy_o     = (state_q != IDLE) && !done_o;
  assign mem_addr_o = rdAddr_q;
  assign mem_rd_o   = issue;

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Directed bench for fb_scan_ctrl on a 4x3 frame, with a second instance placed at the top of memory.
module tb_fb_scan_ctrl;

  localparam int     AW     = 17;
  localparam int     DW     = 16;
  localparam int     HRES   = 4;
  localparam int     VRES   = 3;
  localparam int     NPIX   = HRES * VRES;
  localparam longint BASE_A = 'h10;
  localparam longint BASE_B = (longint'(1) << AW) - 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pxReady, startA, startB, selB;

  logic          busyA, doneA, memRdA, pxValidA, pxEolA, pxEofA;
  logic [AW-1:0] memAddrA;
  logic [DW-1:0] memDataA, pxDataA;
  logic          busyB, doneB, memRdB, pxValidB, pxEolB, pxEofB;
  logic [AW-1:0] memAddrB;
  logic [DW-1:0] memDataB, pxDataB;

  fb_scan_ctrl #(.AW(AW), .DW(DW), .H_RES(HRES), .V_RES(VRES), .BASE(BASE_A)) dutA (
    .clk_i(clk), .rst_i(rst), .start_i(startA), .busy_o(busyA), .done_o(doneA),
    .mem_addr_o(memAddrA), .mem_rd_o(memRdA), .mem_data_i(memDataA),
    .px_data_o(pxDataA), .px_valid_o(pxValidA), .px_ready_i(pxReady),
    .px_eol_o(pxEolA), .px_eof_o(pxEofA)
  );

  fb_scan_ctrl #(.AW(AW), .DW(DW), .H_RES(HRES), .V_RES(VRES), .BASE(BASE_B)) dutB (
    .clk_i(clk), .rst_i(rst), .start_i(startB), .busy_o(busyB), .done_o(doneB),
    .mem_addr_o(memAddrB), .mem_rd_o(memRdB), .mem_data_i(memDataB),
    .px_data_o(pxDataB), .px_valid_o(pxValidB), .px_ready_i(pxReady),
    .px_eol_o(pxEolB), .px_eof_o(pxEofB)
  );

  // Behavioural RAMs holding mem[a] = a with one cycle of read latency.
  always @(posedge clk) begin
    if (memRdA) memDataA <= DW'(memAddrA);
    if (memRdB) memDataB <= DW'(memAddrB);
  end

  logic          busyS, doneS, memRdS, pxValidS, pxEolS, pxEofS;
  logic [AW-1:0] memAddrS;
  logic [DW-1:0] pxDataS;
  logic [1:0]    fifoCountS;
  assign busyS      = selB ? busyB    : busyA;
  assign doneS      = selB ? doneB    : doneA;
  assign memRdS     = selB ? memRdB   : memRdA;
  assign pxValidS   = selB ? pxValidB : pxValidA;
  assign pxEolS     = selB ? pxEolB   : pxEolA;
  assign pxEofS     = selB ? pxEofB   : pxEofA;
  assign memAddrS   = selB ? memAddrB : memAddrA;
  assign pxDataS    = selB ? pxDataB  : pxDataA;
  assign fifoCountS = selB ? dutB.uFifo.count_o : dutA.uFifo.count_o;

  int errorCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // readyMode 0: always ready; 1: alternating 1,0,...; 2: held low for 20 cycles after first valid.
  task automatic applyStimulus(input bit useB, input int readyMode, input int extraStartAt,
                               input int resetAtHs, input string name);
    longint      base = useB ? BASE_B : BASE_A;
    int          hs = 0, reads = 0, firstValid = -1, doneRel = -1, doneCount = 0, maxC = 0;
    logic [31:0] lastAddr = '0;
    logic [17:0] prevPx = '0;
    bit          prevStall = 1'b0, stopped = 1'b0, didReset = 1'b0;
    selB = useB;
    @(negedge clk);
    pxReady = (readyMode == 0);
    if (useB) startB = 1'b1; else startA = 1'b1;
    @(posedge clk);
    for (int rel = 1; rel <= 150 && !stopped; rel++) begin
      @(negedge clk);
      startA = 1'b0;
      startB = 1'b0;
      if (rel == extraStartAt) begin
        if (useB) startB = 1'b1; else startA = 1'b1;
      end
      if (pxValidS && firstValid < 0) firstValid = rel;
      case (readyMode)
        0:       pxReady = 1'b1;
        1:       pxReady = (rel % 2 == 1);
        default: pxReady = (firstValid >= 0) && (rel >= firstValid + 20);
      endcase
      #1;
      if (rel == 1) begin
        checkOutput({name, ".rd1"}, 32'(memRdS), 32'd1);
        checkOutput({name, ".addr1"}, 32'(memAddrS), 32'(base));
        checkOutput({name, ".busy1"}, 32'(busyS), 32'd1);
        checkOutput({name, ".valid1"}, 32'(pxValidS), 32'd0);
      end
      if (rel == 2) checkOutput({name, ".valid2"}, 32'(pxValidS), 32'd0);
      if (rel == 3) checkOutput({name, ".valid3"}, 32'(pxValidS), 32'd1);
      if (prevStall) checkOutput({name, ".stable"}, 32'({pxDataS, pxEolS, pxEofS}), 32'(prevPx));
      if (32'(fifoCountS) > 32'(maxC)) maxC = int'(fifoCountS);
      if (memRdS) begin
        checkOutput({name, ".raddr"}, 32'(memAddrS), 32'(base + reads));
        lastAddr = 32'(memAddrS);
        reads++;
      end
      if (readyMode == 2 && firstValid >= 0 && rel == firstValid + 19) begin
        checkOutput({name, ".stallReads"}, 32'(reads), 32'd2);
        checkOutput({name, ".stallRd"}, 32'(memRdS), 32'd0);
      end
      if (doneS) begin
        doneCount++;
        if (doneRel < 0) doneRel = rel;
        checkOutput({name, ".busyAtDone"}, 32'(busyS), 32'd0);
      end
      if (pxValidS && pxReady) begin
        checkOutput({name, ".data"}, 32'(pxDataS), 32'((base + hs) & 'hFFFF));
        checkOutput({name, ".eol"}, 32'(pxEolS), 32'(hs % HRES == HRES - 1));
        checkOutput({name, ".eof"}, 32'(pxEofS), 32'(hs == NPIX - 1));
        if (readyMode == 0) checkOutput({name, ".hsCycle"}, 32'(rel), 32'(3 + hs));
        hs++;
        if (hs == resetAtHs) begin
          rst = 1'b1;
          @(negedge clk);
          #1;
          checkOutput({name, ".rstBusy"}, 32'(busyS), 32'd0);
          checkOutput({name, ".rstDone"}, 32'(doneS), 32'd0);
          checkOutput({name, ".rstRd"}, 32'(memRdS), 32'd0);
          checkOutput({name, ".rstValid"}, 32'(pxValidS), 32'd0);
          checkOutput({name, ".rstFlags"}, 32'({pxEolS, pxEofS}), 32'd0);
          checkOutput({name, ".rstData"}, 32'(pxDataS), 32'd0);
          checkOutput({name, ".rstAddr"}, 32'(memAddrS), 32'(base));
          rst = 1'b0;
          stopped = 1'b1;
          didReset = 1'b1;
        end
      end
      prevStall = pxValidS && !pxReady;
      prevPx = {pxDataS, pxEolS, pxEofS};
      if (doneRel >= 0 && rel >= doneRel + 6) stopped = 1'b1;
    end
    if (!didReset) begin
      checkOutput({name, ".doneCount"}, 32'(doneCount), 32'd1);
      checkOutput({name, ".pixels"}, 32'(hs), 32'(NPIX));
      checkOutput({name, ".reads"}, 32'(reads), 32'(NPIX));
      checkOutput({name, ".lastAddr"}, lastAddr, 32'(base + NPIX - 1));
      checkOutput({name, ".maxCount"}, 32'(maxC <= 2), 32'd1);
      checkOutput({name, ".idleBusy"}, 32'(busyS), 32'd0);
      if (readyMode == 0) checkOutput({name, ".doneCycle"}, 32'(doneRel), 32'd15);
    end
  endtask

  initial begin
    rst     = 1'b1;
    startA  = 1'b0;
    startB  = 1'b0;
    pxReady = 1'b0;
    selB    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", 32'(busyA), 32'd0);
    checkOutput("reset.valid", 32'(pxValidA), 32'd0);
    checkOutput("reset.rd", 32'(memRdA), 32'd0);
    checkOutput("reset.addr", 32'(memAddrA), 32'(BASE_A));
    rst = 1'b0;

    applyStimulus(1'b0, 0, -1, -1, "stream");
    applyStimulus(1'b0, 1, -1, -1, "alternate");
    applyStimulus(1'b0, 2, -1, -1, "stall");
    applyStimulus(1'b0, 0, 5, -1, "restart");
    applyStimulus(1'b0, 0, -1, 6, "midReset");
    applyStimulus(1'b0, 0, -1, -1, "afterReset");
    applyStimulus(1'b1, 0, -1, -1, "topOfMem");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
